// File: rtl/dec16_timer.sv
// dec16_timer: loadable countdown timer with terminal-count and wrap detection.
// The control unit loads a count, starts it, and waits for the fim pulse.
// An optional auto-reload mode restarts from the last loaded value.
module dec16_timer #(
  parameter int unsigned WIDTH       = 16,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carga,
  input  logic [WIDTH-1:0] entrada,
  input  logic             inicia,
  input  logic             pausa,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] saida,
  output logic             zero,
  output logic             ocupado,
  output logic             fim,
  output logic             borrow_out
);

  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] CONTANDO = 2'd1;
  localparam logic [1:0] PAUSADO  = 2'd2;
  localparam logic [1:0] FIM      = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [WIDTH-1:0] saida_r;
  logic [WIDTH-1:0] saida_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
  logic             fim_r;
  logic             fim_s;
  logic             borrow_r;
  logic             borrow_s;
  logic [WIDTH:0]   diff_s;
  logic             under_s;
  logic             terminal_s;

  // Subtract 1 (or 2 when borrow is requested); the extra top bit flags a wrap below zero.
  function automatic logic [WIDTH:0] sub_step(input logic [WIDTH-1:0] v, input logic b);
    sub_step = {1'b0, v} - {{WIDTH{1'b0}}, 1'b1} - {{WIDTH{1'b0}}, b};
  endfunction

  // Decrement datapath and terminal detection for the current counter value.
  always_comb begin
    diff_s     = sub_step(saida_r, borrow_in);
    under_s    = diff_s[WIDTH];
    terminal_s = under_s | (diff_s[WIDTH-1:0] == {WIDTH{1'b0}});
  end

  // Next-state logic: carga beats pausa, pausa beats inicia, inicia beats counting.
  always_comb begin
    state_s  = state_r;
    saida_s  = saida_r;
    reload_s = reload_r;
    fim_s    = 1'b0;
    borrow_s = 1'b0;
    if (carga) begin
      saida_s  = entrada;
      reload_s = entrada;
      state_s  = OCIOSO;
    end else begin
      case (state_r)
        OCIOSO, FIM: begin
          if (inicia) begin
            if (saida_r != {WIDTH{1'b0}}) begin
              state_s = CONTANDO;
            end else begin
              // Starting from zero finishes immediately without touching the value.
              state_s = FIM;
              fim_s   = 1'b1;
            end
          end else begin
            state_s = state_r;
          end
        end
        CONTANDO: begin
          if (pausa) begin
            state_s = PAUSADO;
          end else if (terminal_s) begin
            fim_s    = 1'b1;
            borrow_s = under_s;
            if (AUTO_RELOAD) begin
              saida_s = reload_r;
              if (reload_r == {WIDTH{1'b0}}) begin
                state_s = FIM;
              end else begin
                state_s = CONTANDO;
              end
            end else begin
              // Hold the post-decrement value, including the wrapped one.
              saida_s = diff_s[WIDTH-1:0];
              state_s = FIM;
            end
          end else begin
            saida_s = diff_s[WIDTH-1:0];
          end
        end
        PAUSADO: begin
          if (pausa) begin
            state_s = PAUSADO;
          end else if (inicia) begin
            state_s = CONTANDO;
          end else begin
            state_s = PAUSADO;
          end
        end
        default: begin
          state_s = OCIOSO;
        end
      endcase
    end
  end

  // State, counter, reload value and event pulses; reset aborts with no pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= OCIOSO;
      saida_r  <= {WIDTH{1'b0}};
      reload_r <= {WIDTH{1'b0}};
      fim_r    <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      saida_r  <= saida_s;
      reload_r <= reload_s;
      fim_r    <= fim_s;
      borrow_r <= borrow_s;
    end
  end

  assign saida      = saida_r;
  assign zero       = (saida_r == {WIDTH{1'b0}});
  assign ocupado    = (state_r == CONTANDO);
  assign fim        = fim_r;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_dec16_timer.sv
// Directed bench for dec16_timer: one task per scenario, inline checks.
module tb_dec16_timer;

  logic        clk;
  logic        reset;
  logic        carga;
  logic [15:0] entrada;
  logic        inicia;
  logic        pausa;
  logic        borrow_in;

  logic [15:0] saida;
  logic        zero;
  logic        ocupado;
  logic        fim;
  logic        borrow_out;

  logic [15:0] saida_ar;
  logic        zero_ar;
  logic        ocupado_ar;
  logic        fim_ar;
  logic        borrow_out_ar;

  int total;
  int bad;

  dec16_timer #(.WIDTH(16), .AUTO_RELOAD(1'b0)) dut (
    .clk(clk), .reset(reset), .carga(carga), .entrada(entrada),
    .inicia(inicia), .pausa(pausa), .borrow_in(borrow_in),
    .saida(saida), .zero(zero), .ocupado(ocupado), .fim(fim),
    .borrow_out(borrow_out)
  );

  dec16_timer #(.WIDTH(16), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .reset(reset), .carga(carga), .entrada(entrada),
    .inicia(inicia), .pausa(pausa), .borrow_in(borrow_in),
    .saida(saida_ar), .zero(zero_ar), .ocupado(ocupado_ar), .fim(fim_ar),
    .borrow_out(borrow_out_ar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    carga = 1'b1; entrada = v; tick(); carga = 1'b0;
  endtask

  task automatic start();
    inicia = 1'b1; tick(); inicia = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    total++; if (saida !== 16'h0000) begin bad++; $display("FAIL reset_saida got=%h want=0000", saida); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", zero); end
    total++; if (ocupado !== 1'b0 || fim !== 1'b0 || borrow_out !== 1'b0) begin
      bad++; $display("FAIL reset_flags ocupado=%b fim=%b borrow=%b want=000", ocupado, fim, borrow_out); end
  endtask

  task automatic test_countdown();
    logic [15:0] exp_v;
    load(16'h0003);
    start();
    total++; if (saida !== 16'h0003 || ocupado !== 1'b1 || fim !== 1'b0) begin
      bad++; $display("FAIL cnt_start saida=%h ocupado=%b fim=%b want=0003/1/0", saida, ocupado, fim); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = 16'h0002 - 16'(i);
      total++; if (saida !== exp_v) begin bad++; $display("FAIL cnt_val%0d got=%h want=%h", i, saida, exp_v); end
      total++; if (fim !== (i == 2)) begin bad++; $display("FAIL cnt_fim%0d got=%b want=%b", i, fim, (i == 2)); end
      total++; if (borrow_out !== 1'b0) begin bad++; $display("FAIL cnt_borrow%0d got=%b want=0", i, borrow_out); end
    end
    total++; if (ocupado !== 1'b0 || zero !== 1'b1) begin
      bad++; $display("FAIL cnt_end ocupado=%b zero=%b want=0/1", ocupado, zero); end
    tick();
    total++; if (fim !== 1'b0 || saida !== 16'h0000) begin
      bad++; $display("FAIL cnt_after fim=%b saida=%h want=0/0000", fim, saida); end
  endtask

  task automatic test_underflow();
    load(16'h0001);
    start();
    borrow_in = 1'b1; tick(); borrow_in = 1'b0;
    total++; if (saida !== 16'hFFFF) begin bad++; $display("FAIL uf_saida got=%h want=ffff", saida); end
    total++; if (fim !== 1'b1 || borrow_out !== 1'b1) begin
      bad++; $display("FAIL uf_pulses fim=%b borrow=%b want=1/1", fim, borrow_out); end
    total++; if (zero !== 1'b0 || ocupado !== 1'b0) begin
      bad++; $display("FAIL uf_state zero=%b ocupado=%b want=0/0", zero, ocupado); end
    tick();
    total++; if (fim !== 1'b0 || borrow_out !== 1'b0 || saida !== 16'hFFFF) begin
      bad++; $display("FAIL uf_hold fim=%b borrow=%b saida=%h want=0/0/ffff", fim, borrow_out, saida); end
  endtask

  task automatic test_pause();
    load(16'h0005);
    start();
    tick(); tick();
    total++; if (saida !== 16'h0003) begin bad++; $display("FAIL pz_pre got=%h want=0003", saida); end
    pausa = 1'b1; tick(); pausa = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin pausa = 1'b1; inicia = 1'b1; end
      else begin pausa = 1'b0; inicia = 1'b0; end
      total++; if (saida !== 16'h0003 || ocupado !== 1'b0) begin
        bad++; $display("FAIL pz_hold%0d saida=%h ocupado=%b want=0003/0", i, saida, ocupado); end
      tick();
    end
    pausa = 1'b0; inicia = 1'b0;
    total++; if (saida !== 16'h0003) begin bad++; $display("FAIL pz_both got=%h want=0003", saida); end
    start();
    total++; if (ocupado !== 1'b1 || saida !== 16'h0003) begin
      bad++; $display("FAIL pz_resume ocupado=%b saida=%h want=1/0003", ocupado, saida); end
    tick(); tick();
    total++; if (saida !== 16'h0001 || fim !== 1'b0) begin
      bad++; $display("FAIL pz_one saida=%h fim=%b want=0001/0", saida, fim); end
    tick();
    total++; if (saida !== 16'h0000 || fim !== 1'b1) begin
      bad++; $display("FAIL pz_fim saida=%h fim=%b want=0000/1", saida, fim); end
  endtask

  task automatic test_autoreload();
    logic [15:0] exp_v;
    load(16'h0002);
    start();
    total++; if (saida_ar !== 16'h0002 || ocupado_ar !== 1'b1) begin
      bad++; $display("FAIL ar_start saida=%h ocupado=%b want=0002/1", saida_ar, ocupado_ar); end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_v = (i % 2 == 0) ? 16'h0001 : 16'h0002;
      total++; if (saida_ar !== exp_v || fim_ar !== (i % 2 == 1)) begin
        bad++; $display("FAIL ar_seq%0d saida=%h fim=%b want=%h/%b", i, saida_ar, fim_ar, exp_v, (i % 2 == 1)); end
      total++; if (ocupado_ar !== 1'b1 || borrow_out_ar !== 1'b0) begin
        bad++; $display("FAIL ar_busy%0d ocupado=%b borrow=%b want=1/0", i, ocupado_ar, borrow_out_ar); end
    end
    load(16'h0000);
  endtask

  task automatic test_zero_load();
    load(16'h0000);
    start();
    total++; if (fim !== 1'b1 || saida !== 16'h0000 || borrow_out !== 1'b0 || ocupado !== 1'b0) begin
      bad++; $display("FAIL z_start fim=%b saida=%h borrow=%b ocupado=%b want=1/0000/0/0", fim, saida, borrow_out, ocupado); end
    tick();
    total++; if (fim !== 1'b0) begin bad++; $display("FAIL z_once got=%b want=0", fim); end
    start();
    total++; if (fim !== 1'b1 || saida !== 16'h0000) begin
      bad++; $display("FAIL z_rearm fim=%b saida=%h want=1/0000", fim, saida); end
  endtask

  task automatic test_reset_abort_and_load();
    load(16'hFFFF);
    start();
    tick(); tick(); tick();
    total++; if (saida !== 16'hFFFC) begin bad++; $display("FAIL ra_pre got=%h want=fffc", saida); end
    reset = 1'b1; tick(); reset = 1'b0;
    total++; if (saida !== 16'h0000 || ocupado !== 1'b0 || fim !== 1'b0) begin
      bad++; $display("FAIL ra_abort saida=%h ocupado=%b fim=%b want=0000/0/0", saida, ocupado, fim); end
    reset = 1'b1; carga = 1'b1; entrada = 16'h5555; tick(); reset = 1'b0; carga = 1'b0;
    total++; if (saida !== 16'h0000) begin bad++; $display("FAIL ra_prio got=%h want=0000", saida); end
    load(16'h0010);
    start();
    tick();
    total++; if (saida !== 16'h000F) begin bad++; $display("FAIL ld_pre got=%h want=000f", saida); end
    load(16'h1234);
    total++; if (saida !== 16'h1234 || ocupado !== 1'b0 || fim !== 1'b0) begin
      bad++; $display("FAIL ld_mid saida=%h ocupado=%b fim=%b want=1234/0/0", saida, ocupado, fim); end
    tick();
    total++; if (saida !== 16'h1234) begin bad++; $display("FAIL ld_idle got=%h want=1234", saida); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; carga = 1'b0; entrada = 16'h0000;
    inicia = 1'b0; pausa = 1'b0; borrow_in = 1'b0;
    #2;
    test_reset();
    test_countdown();
    test_underflow();
    test_pause();
    test_autoreload();
    test_zero_load();
    test_reset_abort_and_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec16_timer.md
Name: dec16_timer

Overview:
- 16-bit countdown timer. Holds a loadable register and decrements it by one per enabled cycle.
- Signals terminal count and detects borrow/wrap.
- Downward counterpart of the inc16 incrementer in the ALUs folder.
- Used as a delay/loop counter beside the PC and ALU datapath; the control unit loads a count, starts it, and waits for `fim`.

Parameters:
- WIDTH, 16, counter and data width in bits.
- AUTO_RELOAD, 0, when 1 the counter reloads the last loaded value on reaching zero and keeps running.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- carga  input  1  load strobe; captures `entrada` into the counter and the reload register.
- entrada  input  WIDTH  value to load.
- inicia  input  1  start/resume request.
- pausa  input  1  pause request, honoured only while counting.
- borrow_in  input  1  when 1 during a counting cycle, the decrement step is 2 instead of 1 (mirror of carry_in).
- saida  output  WIDTH  current counter value.
- zero  output  1  combinational: `saida == 0`.
- ocupado  output  1  high in state CONTANDO.
- fim  output  1  one-cycle pulse on the cycle the count reaches or crosses zero.
- borrow_out  output  1  one-cycle pulse when a decrement underflows below zero (wrap).

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - `saida` = 0, reload register = 0, state = OCIOSO.
  - `fim` = 0, `borrow_out` = 0, `ocupado` = 0, `zero` = 1.
  - Reset mid-count aborts with no `fim` pulse.
- States: OCIOSO, CONTANDO, PAUSADO, FIM.
- Priority per cycle: reset > carga > pausa > inicia > count.
- `carga` in any state:
  - `saida` and the reload register ← `entrada` next cycle.
  - State → OCIOSO; no decrement that cycle; `fim`/`borrow_out` stay 0.
- OCIOSO:
  - `inicia` & `saida` ≠ 0 → CONTANDO.
  - `inicia` & `saida` == 0 → FIM with a `fim` pulse next cycle; no decrement.
- CONTANDO, each cycle:
  - Step = 1 + `borrow_in`; `saida` ← (`saida` − step) mod 2^WIDTH. First decrement happens on the first cycle in CONTANDO (one cycle after `inicia`).
  - New value == 0, or the subtraction underflows: `fim` = 1 for one cycle.
  - Underflow only (e.g. `saida` = 1 with step 2 → 0xFFFF): `borrow_out` = 1 for one cycle.
  - On terminal, AUTO_RELOAD = 0: → FIM, holding the post-decrement value. The underflow case holds 0xFFFF.
  - On terminal, AUTO_RELOAD = 1: `saida` ← reload value instead of the decremented value; stay in CONTANDO. If the reload value is 0 → FIM.
  - `pausa` → PAUSADO, no decrement that cycle.
- PAUSADO: value frozen; `inicia` → CONTANDO. `pausa` & `inicia` asserted together resolve as pause.
- FIM:
  - Value held, `ocupado` = 0.
  - `inicia` re-arms as in OCIOSO, using the current `saida` (0 → immediate `fim` again).
  - `carga` → OCIOSO.
- Output timing:
  - `fim` and `borrow_out` are registered pulses; each lasts exactly one cycle per event.
  - `ocupado` is decoded from state.
  - `zero` is combinational from `saida`.
- Latency: load N ≥ 1, assert `inicia` at cycle t, `borrow_in` = 0 → `fim` at cycle t+N and `saida` = 0 at that same edge.

Test Plan:
- Reset, then load 0x0003, pulse `inicia` → `saida` 3,2,1,0 on consecutive cycles; `fim` high exactly one cycle with `saida` = 0; `ocupado` then 0; `borrow_out` never high.
- Load 0x0001, `inicia`, `borrow_in` = 1 → `saida` = 0xFFFF; `fim` = 1 and `borrow_out` = 1 for one cycle; state FIM; `zero` = 0.
- Load 0x0005, start, assert `pausa` after two decrements → `saida` holds 0x0003 for 4 cycles; `inicia` resumes to 0 with `fim` pulse at the expected cycle.
- AUTO_RELOAD = 1, load 0x0002, start → sequence 2,1,2,1,…; `fim` pulses every 2 cycles; `ocupado` stays 1.
- Load 0x0000, `inicia` → no decrement, `fim` pulse next cycle, `saida` = 0, `borrow_out` = 0.
- Load 0xFFFF, start, assert `reset` after 3 cycles → next cycle `saida` = 0, `ocupado` = 0, no `fim`. Then `carga` with 0x1234 during CONTANDO → `saida` = 0x1234, state OCIOSO.
